// File: rtl/intermed_pipe_pkg.sv
// Shared types and the per-bit intermediate operator for the intermed_pipe block.
package intermed_pkg;

    typedef enum logic [1:0] {
        MODE_AND  = 2'd0,
        MODE_OR   = 2'd1,
        MODE_XOR  = 2'd2,
        MODE_NAND = 2'd3
    } mode_t;

    // One bit of the mode-selected intermediate op; callers apply it across the word.
    function automatic logic inter_op(input mode_t mode, input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (mode)
            MODE_AND:  r = a & b;
            MODE_OR:   r = a | b;
            MODE_XOR:  r = a ^ b;
            MODE_NAND: r = ~(a & b);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/intermed_pipe_if.sv
// Valid/ready input and output bus of intermed_pipe, plus the delivered-result counter.
interface intermed_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic [WIDTH-1:0] in_3;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_1;
    logic [WIDTH-1:0] out_2;
    logic [CNT_W-1:0] out_count;

    // Producer/consumer side driving beats in and taking results out.
    modport master (
        output in_valid, in_1, in_2, in_3, in_mode, out_ready,
        input  in_ready, out_valid, out_1, out_2, out_count
    );

    // The pipeline itself.
    modport slave (
        input  in_valid, in_1, in_2, in_3, in_mode, out_ready,
        output in_ready, out_valid, out_1, out_2, out_count
    );
endinterface

// File: rtl/intermed_pipe_stage.sv
// Generic valid/ready register slice: accepts whenever empty or draining this cycle.
module intermed_stage #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);
    logic          valid_q, valid_d;
    logic [PW-1:0] data_q,  data_d;

    // Next-state: refill or clear when the slot frees up, otherwise hold.
    always_comb begin
        in_ready = ~valid_q | out_ready;
        valid_d  = valid_q;
        data_d   = data_q;
        if (in_ready) begin
            valid_d = in_valid;
        end
        if (in_valid && in_ready) begin
            data_d = in_data;
        end
    end

    // Slice register; the payload is cleared on reset too so no stale value is visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
endmodule

// File: rtl/intermed_pipe.sv
// Two-stage pipelined combiner: stage 1 = in_1 op in_2 (plus aligned in_3),
// stage 2 = (inter & in_3, inter | in_3). Full throughput with backpressure.
module intermed_pipe
    import intermed_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    intermed_pipe_if.slave bus
);
    logic [WIDTH-1:0]   inter;
    logic [2*WIDTH-1:0] s1_in_data;
    logic [2*WIDTH-1:0] s1_data;
    logic               s1_valid;
    logic               s2_in_ready;
    logic [WIDTH-1:0]   s1_inter;
    logic [WIDTH-1:0]   s1_c;
    logic [2*WIDTH-1:0] s2_in_data;
    logic [2*WIDTH-1:0] s2_data;
    logic               s2_valid;
    logic [CNT_W-1:0]   count_q, count_d;

    // Intermediate op, applied bit by bit with the mode carried by this beat.
    always_comb begin
        inter = '0;
        for (int i = 0; i < WIDTH; i++) begin
            inter[i] = inter_op(mode_t'(bus.in_mode), bus.in_1[i], bus.in_2[i]);
        end
    end

    // in_3 rides along with the intermediate so it stays aligned with its beat.
    assign s1_in_data = {inter, bus.in_3};

    intermed_stage #(.PW(2*WIDTH)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (s1_in_data),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_data)
    );

    assign s1_inter   = s1_data[2*WIDTH-1:WIDTH];
    assign s1_c       = s1_data[WIDTH-1:0];
    assign s2_in_data = {s1_inter & s1_c, s1_inter | s1_c};

    intermed_stage #(.PW(2*WIDTH)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_in_data),
        .out_valid (s2_valid),
        .out_ready (bus.out_ready),
        .out_data  (s2_data)
    );

    assign bus.out_valid = s2_valid;
    assign bus.out_1     = s2_data[2*WIDTH-1:WIDTH];
    assign bus.out_2     = s2_data[WIDTH-1:0];

    // Delivered-result counter, free-running wrap.
    always_comb begin
        count_d = count_q;
        if (s2_valid && bus.out_ready) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.out_count = count_q;
endmodule

// File: tb/tb_intermed_pipe.sv
// Directed bench for intermed_pipe (WIDTH = 8, CNT_W = 4 so the counter wrap is reachable).
module tb_intermed_pipe;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   exp_count;

    intermed_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    intermed_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference for one result beat, written directly from the op definitions.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [1:0] m);
        logic [7:0] t;
        case (m)
            2'd0:    t = a & b;
            2'd1:    t = a | b;
            2'd2:    t = a ^ b;
            default: t = ~(a & b);
        endcase
        return {t & c, t | c};
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [1:0] m);
        bus.in_valid = 1'b1;
        bus.in_1     = a;
        bus.in_2     = b;
        bus.in_3     = c;
        bus.in_mode  = m;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_count = 0;
        #1;
    endtask

    // Single beat with hand-computed results; checks latency and the count step.
    task automatic one_beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [1:0] m,
                            input logic [7:0] e1, input logic [7:0] e2);
        bus.out_ready = 1'b0;
        drive(a, b, c, m);
        #1;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_out_1"}, 32'(bus.out_1), 32'(e1));
        chk({tag, "_out_2"}, 32'(bus.out_2), 32'(e2));
        bus.out_ready = 1'b1;
        tick();
        exp_count++;
        chk({tag, "_count"}, 32'(bus.out_count), 32'(exp_count % 16));
        chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] e;
        logic [7:0]  va [0:16];
        logic [7:0]  vb [0:16];
        logic [7:0]  vc [0:16];
        n_tests = 0;
        n_fail  = 0;
        exp_count = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_1 = '0;
        bus.in_2 = '0;
        bus.in_3 = '0;
        bus.in_mode = 2'd0;
        bus.out_ready = 1'b0;

        for (int i = 0; i < 17; i++) begin
            va[i] = 8'((i * 37) ^ 8'h5A);
            vb[i] = 8'((i * 91) + 8'h13);
            vc[i] = 8'((i * 23) ^ 8'hC3);
        end

        // Reset state
        do_reset();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.out_count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_1", 32'(bus.out_1), 32'd0);

        // Single beats, each mode: A=F0 B=3C C=0F
        one_beat("and",  8'hF0, 8'h3C, 8'h0F, 2'd0, 8'h00, 8'h3F);
        one_beat("xor",  8'hF0, 8'h3C, 8'h0F, 2'd2, 8'h0C, 8'hCF);
        one_beat("nand", 8'hF0, 8'h3C, 8'h0F, 2'd3, 8'h0F, 8'hCF);
        one_beat("or",   8'hF0, 8'h3C, 8'h0F, 2'd1, 8'h0C, 8'hFF);

        // Back-to-back stream of 10 beats, mixed modes
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) begin
                drive(va[k], vb[k], vc[k], 2'(k % 4));
                #1;
                chk($sformatf("str_in_ready_%0d", k), 32'(bus.in_ready), 32'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (k >= 1) begin
                e = model(va[k-1], vb[k-1], vc[k-1], 2'((k - 1) % 4));
                chk($sformatf("str_valid_%0d", k - 1), 32'(bus.out_valid), 32'd1);
                chk($sformatf("str_out_1_%0d", k - 1), 32'(bus.out_1), 32'(e[15:8]));
                chk($sformatf("str_out_2_%0d", k - 1), 32'(bus.out_2), 32'(e[7:0]));
            end
        end
        tick();
        chk("str_count", 32'(bus.out_count), 32'd10);
        chk("str_drained", 32'(bus.out_valid), 32'd0);

        // Backpressure: 3 beats offered with out_ready low
        do_reset();
        bus.out_ready = 1'b0;
        drive(8'hAA, 8'h0F, 8'h33, 2'd2);     // X: inter A5 -> 21 / B7
        #1;
        chk("bp_rdy_x", 32'(bus.in_ready), 32'd1);
        tick();
        drive(8'h12, 8'h34, 8'hF0, 2'd1);     // Y: inter 36 -> 30 / F6
        #1;
        chk("bp_rdy_y", 32'(bus.in_ready), 32'd1);
        tick();
        drive(8'hFF, 8'h81, 8'h7E, 2'd0);     // Z: inter 81 -> 00 / FF
        #1;
        chk("bp_rdy_z_full", 32'(bus.in_ready), 32'd0);
        tick();
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_out_1", 32'(bus.out_1), 32'h21);
        chk("bp_hold_out_2", 32'(bus.out_2), 32'hB7);
        tick();
        chk("bp_stable_out_1", 32'(bus.out_1), 32'h21);
        chk("bp_stable_out_2", 32'(bus.out_2), 32'hB7);
        chk("bp_stable_count", 32'(bus.out_count), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_y_out_1", 32'(bus.out_1), 32'h30);
        chk("bp_y_out_2", 32'(bus.out_2), 32'hF6);
        tick();
        chk("bp_z_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_z_out_1", 32'(bus.out_1), 32'h00);
        chk("bp_z_out_2", 32'(bus.out_2), 32'hFF);
        tick();
        chk("bp_done_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_count", 32'(bus.out_count), 32'd3);

        // Reset with both stages full, an accept offered during reset
        bus.out_ready = 1'b0;
        drive(8'h0F, 8'hFF, 8'h01, 2'd1);
        tick();
        tick();
        chk("rf_full_rdy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        chk("rf_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rf_count", 32'(bus.out_count), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rf_no_stale_%0d", k), 32'(bus.out_valid), 32'd0);
        end
        chk("rf_count_after", 32'(bus.out_count), 32'd0);

        // 17 beats with a 4-bit counter: wraps to 1
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            drive(va[k], vb[k], vc[k], 2'd2);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        chk("wrap_last_out_1", 32'(bus.out_1),
            32'(((va[16] ^ vb[16]) & vc[16])));
        tick();
        chk("wrap_count", 32'(bus.out_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
